// File: rtl/ram_dp_arbiter_if.sv
// Requester-side bus of the dual-port RAM arbiter: two requesters packed side by side,
// requester n occupies bit n of the control vectors and slice n of address/data.
interface ram_dp_arbiter_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic [1:0]          req_valid;
  logic [1:0]          req_we;
  logic [2*AWIDTH-1:0] req_addr;
  logic [2*DWIDTH-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DWIDTH-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_dp_arbiter.sv
// Shares one write port and one registered read port of a dual-port RAM between two
// requesters, with independent round-robin arbitration and write-to-read forwarding.
module ram_dp_arbiter #(
  parameter int DEPTH  = 32,
  parameter int AWIDTH = $clog2(DEPTH),
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  ram_dp_arbiter_if.slave   bus,
  output logic              wenable,
  output logic [AWIDTH-1:0] waddr,
  output logic [DWIDTH-1:0] wdata,
  output logic              renable,
  output logic [AWIDTH-1:0] raddr,
  input  logic [DWIDTH-1:0] rdata
);

  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_rsp_valid;
  logic              r_bypass;
  logic [DWIDTH-1:0] r_fwd_data;

  logic [1:0]        w_wcand;
  logic [1:0]        w_rcand;
  logic              w_wsel;
  logic              w_rsel;
  logic              w_wgnt;
  logic              w_rgnt;
  logic [1:0]        w_wgnt_vec;
  logic [1:0]        w_rgnt_vec;

  assign w_wcand = bus.req_valid & bus.req_we;
  assign w_rcand = bus.req_valid & ~bus.req_we;

  // Under contention the pointer decides; otherwise the lone candidate wins.
  assign w_wsel = (&w_wcand) ? r_wptr : w_wcand[1];
  assign w_rsel = (&w_rcand) ? r_rptr : w_rcand[1];

  // Grants are masked by reset so every RAM-facing output reads zero while rst is high.
  assign w_wgnt = (|w_wcand) & ~rst;
  assign w_rgnt = (|w_rcand) & ~rst;

  assign w_wgnt_vec = {w_wgnt & w_wsel, w_wgnt & ~w_wsel};
  assign w_rgnt_vec = {w_rgnt & w_rsel, w_rgnt & ~w_rsel};

  assign wenable = w_wgnt;
  assign waddr   = !w_wgnt ? '0 :
                   (w_wsel ? bus.req_addr[2*AWIDTH-1:AWIDTH] : bus.req_addr[AWIDTH-1:0]);
  assign wdata   = !w_wgnt ? '0 :
                   (w_wsel ? bus.req_wdata[2*DWIDTH-1:DWIDTH] : bus.req_wdata[DWIDTH-1:0]);

  assign renable = w_rgnt;
  assign raddr   = !w_rgnt ? '0 :
                   (w_rsel ? bus.req_addr[2*AWIDTH-1:AWIDTH] : bus.req_addr[AWIDTH-1:0]);

  assign bus.req_ready = w_wgnt_vec | w_rgnt_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_bypass    <= 1'b0;
      r_fwd_data  <= '0;
    end else begin
      if (w_wgnt) r_wptr <= ~w_wsel;
      if (w_rgnt) r_rptr <= ~w_rsel;
      r_rsp_valid <= w_rgnt_vec;
      // Write-first: a same-cycle write to the read address overrides the RAM output.
      r_bypass    <= w_rgnt & w_wgnt & (waddr == raddr);
      if (w_wgnt) r_fwd_data <= wdata;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = (|r_rsp_valid) ? (r_bypass ? r_fwd_data : rdata) : '0;

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Directed and random checks of ram_dp_arbiter against a behavioural RAM and a mirror memory.
module tb_ram_dp_arbiter;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int NSOAK = 3 * DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_dp_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  logic          wenable, renable;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, rdata;

  ram_dp_arbiter #(.DEPTH(DEPTH), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .wenable (wenable),
    .waddr   (waddr),
    .wdata   (wdata),
    .renable (renable),
    .raddr   (raddr),
    .rdata   (rdata)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (wenable) mem[waddr] <= wdata;
    if (renable) rdata <= mem[raddr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[n]          = v;
    bus.req_we[n]             = we;
    bus.req_addr[n*AW +: AW]  = a;
    bus.req_wdata[n*DW +: DW] = d;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]    pend_v, pend_we, exp_v, prev;
  logic [AW-1:0] pa [2];
  logic [DW-1:0] pd [2];
  int            wait_c [2];
  logic [DW-1:0] mirror [DEPTH];
  logic [DW-1:0] exp_d, wd;
  logic [AW-1:0] wa, ra;
  logic          wg, rg;
  int            rn, nw, issued, cnt0, cnt1;

  initial begin
    foreach (mem[i]) mem[i] = '0;
    idle();
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 5'd3, 8'hAA);
    drive(1, 1'b1, 1'b0, 5'd4, 8'h00);
    @(negedge clk);
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 0);
    check_eq("rst_wenable", wenable, 0);
    check_eq("rst_waddr", waddr, 0);
    check_eq("rst_wdata", wdata, 0);
    check_eq("rst_renable", renable, 0);
    check_eq("rst_raddr", raddr, 0);
    idle();
    to_pos();
    rst = 1'b0;

    // Single write by req0 moves wptr to 1, so a later req0 win proves the pointer reset.
    drive(0, 1'b1, 1'b1, 5'd0, 8'h99);
    @(negedge clk);
    check_eq("pre_wr_ready", bus.req_ready, 2'b01);
    to_pos();
    idle();
    drive(1, 1'b1, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    check_eq("mid_rd_ready", bus.req_ready, 2'b10);
    check_eq("mid_rd_renable", renable, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", bus.req_ready, 0);
    check_eq("mid_rst_renable", renable, 0);
    idle();
    @(negedge clk);
    check_eq("rst_drop_rsp", bus.rsp_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_rsp", bus.rsp_valid, 0);
    to_pos();

    // Write contention
    drive(0, 1'b1, 1'b1, 5'd3, 8'hAA);
    drive(1, 1'b1, 1'b1, 5'd5, 8'h55);
    @(negedge clk);
    check_eq("wc1_ready", bus.req_ready, 2'b01);
    check_eq("wc1_waddr", waddr, 3);
    check_eq("wc1_wdata", wdata, 8'hAA);
    to_pos();
    drive(0, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    check_eq("wc2_ready", bus.req_ready, 2'b10);
    check_eq("wc2_waddr", waddr, 5);
    check_eq("wc2_wdata", wdata, 8'h55);
    to_pos();
    idle();

    // Readback of both words
    drive(0, 1'b1, 1'b0, 5'd3, 8'h00);
    drive(1, 1'b1, 1'b0, 5'd5, 8'h00);
    @(negedge clk);
    check_eq("rb1_ready", bus.req_ready, 2'b01);
    check_eq("rb1_raddr", raddr, 3);
    to_pos();
    drive(0, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    check_eq("rb1_rsp_valid", bus.rsp_valid, 2'b01);
    check_eq("rb1_rsp_rdata", bus.rsp_rdata, 8'hAA);
    check_eq("rb2_ready", bus.req_ready, 2'b10);
    check_eq("rb2_raddr", raddr, 5);
    to_pos();
    idle();
    @(negedge clk);
    check_eq("rb2_rsp_valid", bus.rsp_valid, 2'b10);
    check_eq("rb2_rsp_rdata", bus.rsp_rdata, 8'h55);
    to_pos();

    // Read fairness: 8 cycles of continuous contention
    drive(0, 1'b1, 1'b0, 5'd3, 8'h00);
    drive(1, 1'b1, 1'b0, 5'd5, 8'h00);
    cnt0 = 0;
    cnt1 = 0;
    prev = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("rf_ready", bus.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      check_eq("rf_rsp_valid", bus.rsp_valid, prev);
      if (prev != 2'b00) check_eq("rf_rsp_rdata", bus.rsp_rdata, prev[0] ? 8'hAA : 8'h55);
      cnt0 += int'(bus.rsp_valid[0]);
      cnt1 += int'(bus.rsp_valid[1]);
      prev = (i % 2 == 0) ? 2'b01 : 2'b10;
      to_pos();
    end
    idle();
    @(negedge clk);
    check_eq("rf_last_valid", bus.rsp_valid, prev);
    check_eq("rf_last_rdata", bus.rsp_rdata, 8'h55);
    cnt0 += int'(bus.rsp_valid[0]);
    cnt1 += int'(bus.rsp_valid[1]);
    check_eq("rf_cnt0", cnt0, 4);
    check_eq("rf_cnt1", cnt1, 4);
    to_pos();

    // Parallel read and write by different requesters
    drive(1, 1'b1, 1'b1, 5'd2, 8'h11);
    @(negedge clk);
    check_eq("pl_pre_ready", bus.req_ready, 2'b10);
    to_pos();
    drive(0, 1'b1, 1'b1, 5'd10, 8'h3C);
    drive(1, 1'b1, 1'b0, 5'd2, 8'h00);
    @(negedge clk);
    check_eq("pl_ready", bus.req_ready, 2'b11);
    check_eq("pl_waddr", waddr, 10);
    check_eq("pl_raddr", raddr, 2);
    to_pos();
    idle();
    @(negedge clk);
    check_eq("pl_rsp_valid", bus.rsp_valid, 2'b10);
    check_eq("pl_rsp_rdata", bus.rsp_rdata, 8'h11);
    to_pos();

    // Same-cycle write/read of one address returns the new data
    drive(0, 1'b1, 1'b1, 5'd7, 8'hE1);
    drive(1, 1'b1, 1'b0, 5'd7, 8'h00);
    @(negedge clk);
    check_eq("fw_ready", bus.req_ready, 2'b11);
    to_pos();
    idle();
    @(negedge clk);
    check_eq("fw_rsp_valid", bus.rsp_valid, 2'b10);
    check_eq("fw_rsp_rdata", bus.rsp_rdata, 8'hE1);
    to_pos();

    // Random soak against a mirror memory
    foreach (mirror[i]) mirror[i] = mem[i];
    pend_v  = '0;
    pend_we = '0;
    exp_v   = '0;
    exp_d   = '0;
    issued  = 0;
    wait_c[0] = 0;
    wait_c[1] = 0;
    for (int cyc = 0; cyc < 2000 && (issued < NSOAK || pend_v != 2'b00); cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend_v[n] && issued < NSOAK && $urandom_range(3) != 0) begin
          pend_v[n]  = 1'b1;
          pend_we[n] = 1'($urandom_range(1));
          pa[n]      = AW'($urandom_range(7));
          pd[n]      = DW'($urandom);
          issued++;
        end
        drive(n, pend_v[n], pend_we[n], pa[n], pd[n]);
      end
      @(negedge clk);
      check_eq("soak_rsp_valid", bus.rsp_valid, exp_v);
      if (exp_v != 2'b00) check_eq("soak_rsp_rdata", bus.rsp_rdata, exp_d);
      check_eq("soak_ready_idle", bus.req_ready & ~pend_v, 0);
      wg = 1'b0;
      rg = 1'b0;
      nw = 0;
      wa = '0; wd = '0; ra = '0; rn = 0;
      for (int n = 0; n < 2; n++) begin
        if (pend_v[n] && bus.req_ready[n]) begin
          check_eq("soak_wait", 32'(wait_c[n] <= 1), 1);
          if (pend_we[n]) begin
            wg = 1'b1; wa = pa[n]; wd = pd[n]; nw++;
          end else begin
            rg = 1'b1; ra = pa[n]; rn = n;
          end
          wait_c[n] = 0;
          pend_v[n] = 1'b0;
        end else if (pend_v[n]) begin
          wait_c[n]++;
        end
      end
      if (pend_v == 2'b11 && pend_we[0] == pend_we[1]) check_eq("soak_one_grant", nw, 0);
      exp_v = rg ? (2'b01 << rn) : 2'b00;
      if (rg) exp_d = (wg && wa == ra) ? wd : mirror[ra];
      if (wg) mirror[wa] = wd;
      to_pos();
    end
    idle();
    @(negedge clk);
    check_eq("soak_final_valid", bus.rsp_valid, exp_v);
    if (exp_v != 2'b00) check_eq("soak_final_rdata", bus.rsp_rdata, exp_d);
    check_eq("soak_issued", issued, NSOAK);
    check_eq("soak_drained", pend_v, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ram_dp_arbiter.md
Name: ram_dp_arbiter

Overview:
- Shares one single-clock dual-port RAM (one write port, one read port, registered read, 1-cycle read latency) between two requesters.
- Each requester issues read or write transactions over a valid/ready handshake.
- Writes are arbitrated round-robin onto the RAM write port. Reads are arbitrated round-robin, independently, onto the RAM read port.
- Read data is routed back to the issuing requester, with same-cycle write-to-read forwarding. Sits between client logic and ram_dual_port (wclk = rclk = clk).

Parameters:
DEPTH, 32, number of RAM words
AWIDTH, $clog2(DEPTH), address width
DWIDTH, 8, data width

Ports:
clk  input  1  single clock (also drives RAM wclk/rclk)
rst  input  1  asynchronous reset, active-high
req_valid  input  2  per-requester request valid, bit n = requester n
req_we  input  2  1 = write, 0 = read
req_addr  input  2*AWIDTH  requester n address in bits [n*AWIDTH +: AWIDTH]
req_wdata  input  2*DWIDTH  requester n write data in bits [n*DWIDTH +: DWIDTH]
req_ready  output  2  grant; transfer when req_valid[n] & req_ready[n]
rsp_valid  output  2  1-cycle pulse, read data valid for requester n
rsp_rdata  output  DWIDTH  read data, meaningful only when a rsp_valid bit is high
wenable  output  1  to RAM write enable
waddr  output  AWIDTH  to RAM write address
wdata  output  DWIDTH  to RAM write data
renable  output  1  to RAM read enable
raddr  output  AWIDTH  to RAM read address
rdata  input  DWIDTH  from RAM, valid the cycle after renable

Behaviour:
Reset
- While rst is high, all outputs are 0: req_ready, rsp_valid, rsp_rdata, wenable, waddr, wdata, renable, raddr.
- Write pointer wptr = 0 and read pointer rptr = 0 (requester 0 has priority).
- Reset mid-operation drops any pending read response; no rsp_valid pulse follows the deassertion of reset.

Write arbitration (combinational, same cycle)
- Candidates: requesters with req_valid & req_we.
- One candidate: grant it. Two candidates: grant requester wptr.
- On grant: wenable = 1; waddr/wdata = granted request fields; req_ready[granted] = 1.
- On a clock edge with a write grant to n, wptr <= 1-n. No grant leaves wptr unchanged.

Read arbitration
- Independent of write arbitration, using rptr and candidates with req_valid & ~req_we.
- On grant: renable = 1; raddr = granted address; req_ready[granted] = 1.
- rptr update follows the same rule as wptr.

Concurrency
- At most one write and one read are granted per cycle. Both requesters can be granted in the same cycle if one reads and the other writes.
- A requester is never granted both: it issues only one request per cycle.

Non-granted requests
- req_ready stays 0. The requester must hold valid and fields stable until granted.
- Round-robin guarantees a grant within 2 cycles under contention.

Read response
- The cycle after a read grant to n: rsp_valid[n] = 1 for exactly one cycle; rsp_rdata = rdata.
- Forwarding: if the write granted in the same cycle targets raddr, the arbiter registers wdata and a bypass flag. rsp_rdata then returns the forwarded write data (write-first), regardless of RAM contention behaviour.
- No response backpressure; back-to-back reads produce back-to-back responses.

Wrap-around / boundaries
- Addresses are not checked; values ≥ DEPTH are passed through unchanged.
- No outstanding-transaction limit is needed: latency is fixed at 1 cycle.

Test Plan:
- Reset: assert rst mid-read (read granted, rst asserted before the response edge) -> rsp_valid stays 0 through and after reset; all outputs 0; the first contended write after reset is granted to requester 0.
- Write contention: both requesters write (addr 3 data 0xAA, addr 5 data 0x55) and hold valid -> cycle 1: req0 granted, waddr = 3; cycle 2: req1 granted, waddr = 5; a subsequent read of 3 and 5 returns 0xAA and 0x55.
- Read fairness: both requesters read continuously for 8 cycles -> grants alternate 0,1,0,1…; each rsp_valid pulses 4 times, one cycle after the corresponding grant, with correct data.
- Parallel read/write: req0 writes addr 10 = 0x3C while req1 reads addr 2 (preloaded 0x11) -> both req_ready high the same cycle; next cycle rsp_valid = 2'b10, rsp_rdata = 0x11.
- Forwarding: req0 writes addr 7 = 0xE1 while req1 reads addr 7 (old 0x00) -> rsp_rdata = 0xE1 the next cycle.
- Random soak: 3*DEPTH random mixed requests checked against a mirror memory -> zero mismatches; no requester waits more than 2 cycles for a grant.
